// File: rtl/alarm_trigger.sv
// alarm_trigger: consumer side of the alarm-setting interface.
// Latches the committed alarm time on ack_flag and compares it against the
// running clock time. It drives the buzzer and handles stop, bounded snooze
// and auto-timeout while ringing.
// Optional feature macro: BUZZER_PULSE_EN (buzzer toggles each second while ringing).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   sec_tick          one-cycle pulse per second, aligned with the new cur_* time
//   cur_hours/minutes/seconds  running clock time
//   i_hours/i_minutes, on_off_alarm, ack_flag  setter interface (latched on ack_flag)
//   stop_button, snooze_button  debounced one-cycle pulses
//   buzzer, ringing, snoozing, snooze_cnt  registered status / drive outputs
module alarm_trigger #(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter int unsigned RING_SEC   = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    input  logic [4:0] i_hours,
    input  logic [5:0] i_minutes,
    input  logic       ack_flag,
    input  logic       on_off_alarm,
    input  logic       stop_button,
    input  logic       snooze_button,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_cnt
);

    localparam logic [1:0] MAX_CNT   = 2'(MAX_SNOOZE);
    localparam logic [7:0] RING_LIM  = 8'(RING_SEC);
    localparam logic [6:0] SNZ_MIN7  = 7'(SNOOZE_MIN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] al_h_q, al_h_d;
    logic [5:0] al_m_q, al_m_d;
    logic       al_en_q, al_en_d;
    logic [4:0] snz_h_q, snz_h_d;
    logic [5:0] snz_m_q, snz_m_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic [1:0] snooze_cnt_q, snooze_cnt_d;
    logic       ringing_q, ringing_d;
    logic       snoozing_q, snoozing_d;

    // Snooze target: current time + SNOOZE_MIN with minute/hour wrap
    logic [6:0] min_sum;
    logic       min_wrap;
    logic [4:0] tgt_h;
    logic [5:0] tgt_m;

    always_comb begin
        min_sum  = 7'(cur_minutes) + SNZ_MIN7;
        min_wrap = (min_sum >= 7'd60);
        tgt_m    = min_wrap ? 6'(min_sum - 7'd60) : 6'(min_sum);
        if (!min_wrap)
            tgt_h = cur_hours;
        else if (cur_hours == 5'd23)
            tgt_h = 5'd0;
        else
            tgt_h = cur_hours + 5'd1;
    end

    // Match qualifiers: only on the tick that starts a new minute
    logic       at_minute;
    logic       alarm_match;
    logic       snooze_match;
    logic [7:0] ring_inc;

    always_comb begin
        at_minute    = sec_tick && (cur_seconds == 6'd0) && al_en_q;
        alarm_match  = at_minute && (cur_hours == al_h_q) && (cur_minutes == al_m_q);
        snooze_match = at_minute && (cur_hours == snz_h_q) && (cur_minutes == snz_m_q);
        ring_inc     = (ring_cnt_q == 8'hFF) ? 8'hFF : ring_cnt_q + 8'd1;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        al_h_d       = al_h_q;
        al_m_d       = al_m_q;
        al_en_d      = al_en_q;
        snz_h_d      = snz_h_q;
        snz_m_d      = snz_m_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;

        if (ack_flag) begin
            al_h_d  = i_hours;
            al_m_d  = i_minutes;
            al_en_d = on_off_alarm;
            // A new commit cancels any active alarm event
            if (state_q != IDLE) begin
                state_d      = IDLE;
                snooze_cnt_d = 2'd0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (alarm_match) begin
                        state_d      = RINGING;
                        ring_cnt_d   = 8'd0;
                        snooze_cnt_d = 2'd0;
                    end
                end
                RINGING: begin
                    if (sec_tick)
                        ring_cnt_d = ring_inc;
                    if (stop_button) begin
                        state_d      = IDLE;
                        snooze_cnt_d = 2'd0;
                    end else if (snooze_button && (snooze_cnt_q < MAX_CNT)) begin
                        state_d      = SNOOZE;
                        snooze_cnt_d = snooze_cnt_q + 2'd1;
                        snz_h_d      = tgt_h;
                        snz_m_d      = tgt_m;
                    end else if (snooze_button) begin
                        state_d      = IDLE;
                        snooze_cnt_d = 2'd0;
                    end else if (sec_tick && (ring_inc >= RING_LIM)) begin
                        state_d      = IDLE;
                        snooze_cnt_d = 2'd0;
                    end
                end
                SNOOZE: begin
                    if (stop_button) begin
                        state_d      = IDLE;
                        snooze_cnt_d = 2'd0;
                    end else if (snooze_match) begin
                        state_d    = RINGING;
                        ring_cnt_d = 8'd0;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    snooze_cnt_d = 2'd0;
                end
            endcase
        end

        ringing_d  = (state_d == RINGING);
        snoozing_d = (state_d == SNOOZE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            al_h_q       <= 5'd0;
            al_m_q       <= 6'd0;
            al_en_q      <= 1'b0;
            snz_h_q      <= 5'd0;
            snz_m_q      <= 6'd0;
            ring_cnt_q   <= 8'd0;
            snooze_cnt_q <= 2'd0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            al_h_q       <= al_h_d;
            al_m_q       <= al_m_d;
            al_en_q      <= al_en_d;
            snz_h_q      <= snz_h_d;
            snz_m_q      <= snz_m_d;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            ringing_q    <= ringing_d;
            snoozing_q   <= snoozing_d;
        end
    end

`ifdef BUZZER_PULSE_EN
    // Buzzer starts on at ring entry, toggles per second, off outside RINGING
    logic buzzer_q, buzzer_d;

    always_comb begin
        buzzer_d = 1'b0;
        if (state_d == RINGING) begin
            if (state_q != RINGING)
                buzzer_d = 1'b1;
            else if (sec_tick)
                buzzer_d = ~buzzer_q;
            else
                buzzer_d = buzzer_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            buzzer_q <= 1'b0;
        else
            buzzer_q <= buzzer_d;
    end

    assign buzzer = buzzer_q;
`else
    assign buzzer = ringing_q;
`endif

    assign ringing    = ringing_q;
    assign snoozing   = snoozing_q;
    assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Testbench for alarm_trigger: directed scenarios plus randomized stimulus,
// checked every cycle against a minute-of-day reference model.
module tb_alarm_trigger;

    localparam int SNOOZE_MIN = 5;
    localparam int MAX_SNOOZE = 3;
    localparam int RING_SEC   = 60;
    localparam int DAY_S      = 86400;
    localparam int DAY_M      = 1440;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [5:0] cur_seconds;
    logic [4:0] i_hours;
    logic [5:0] i_minutes;
    logic       ack_flag;
    logic       on_off_alarm;
    logic       stop_button;
    logic       snooze_button;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_cnt;

    alarm_trigger #(
        .SNOOZE_MIN(SNOOZE_MIN),
        .MAX_SNOOZE(MAX_SNOOZE),
        .RING_SEC  (RING_SEC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sec_tick     (sec_tick),
        .cur_hours    (cur_hours),
        .cur_minutes  (cur_minutes),
        .cur_seconds  (cur_seconds),
        .i_hours      (i_hours),
        .i_minutes    (i_minutes),
        .ack_flag     (ack_flag),
        .on_off_alarm (on_off_alarm),
        .stop_button  (stop_button),
        .snooze_button(snooze_button),
        .buzzer       (buzzer),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .snooze_cnt   (snooze_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Time of day in seconds, driven onto cur_*
    int tod = 0;

    // Reference model: alarm and snooze target held as minute-of-day
    bit m_ring, m_snz, m_en, m_buz;
    int m_cnt, m_rs, m_al, m_tgt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit exp_buz;
`ifdef BUZZER_PULSE_EN
        exp_buz = m_buz;
`else
        exp_buz = m_ring;
`endif
        check("ringing", 32'(ringing), 32'(m_ring));
        check("snoozing", 32'(snoozing), 32'(m_snz));
        check("buzzer", 32'(buzzer), 32'(exp_buz));
        check("snooze_cnt", 32'(snooze_cnt), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_ring = 0; m_snz = 0; m_en = 0; m_buz = 0;
        m_cnt = 0; m_rs = 0; m_al = 0; m_tgt = 0;
    endtask

    task automatic go_idle();
        m_ring = 0;
        m_snz  = 0;
        m_cnt  = 0;
    endtask

    task automatic model_update(input bit ack, input int ah, input int am, input bit on,
                                input bit tick, input bit stop, input bit snz);
        int  tmin;
        bit  new_min;
        bit  was_ring;
        int  nrs;
        tmin     = tod / 60;
        new_min  = tick && ((tod % 60) == 0) && m_en;
        was_ring = m_ring;
        if (ack) begin
            m_al = ah * 60 + am;
            m_en = on;
            if (m_ring || m_snz) go_idle();
        end else if (!m_ring && !m_snz) begin
            if (new_min && tmin == m_al) begin
                m_ring = 1; m_rs = 0; m_cnt = 0;
            end
        end else if (m_ring) begin
            nrs = tick ? ((m_rs < 255) ? m_rs + 1 : 255) : m_rs;
            if (stop) go_idle();
            else if (snz && m_cnt < MAX_SNOOZE) begin
                m_ring = 0; m_snz = 1; m_cnt++;
                m_tgt = (tmin + SNOOZE_MIN) % DAY_M;
            end else if (snz) go_idle();
            else if (nrs >= RING_SEC) go_idle();
            else m_rs = nrs;
        end else begin
            if (stop) go_idle();
            else if (new_min && tmin == m_tgt) begin
                m_snz = 0; m_ring = 1; m_rs = 0;
            end
        end
        if (!m_ring) m_buz = 0;
        else if (!was_ring) m_buz = 1;
        else if (tick) m_buz = !m_buz;
    endtask

    // One clock cycle: drive inputs, clock, update model, compare
    task automatic step(input bit ack, input int ah, input int am, input bit on,
                        input bit tick, input bit stop, input bit snz);
        ack_flag      = ack;
        i_hours       = 5'(ah);
        i_minutes     = 6'(am);
        on_off_alarm  = on;
        sec_tick      = tick;
        stop_button   = stop;
        snooze_button = snz;
        cur_hours     = 5'(tod / 3600);
        cur_minutes   = 6'((tod / 60) % 60);
        cur_seconds   = 6'(tod % 60);
        @(posedge clk);
        model_update(ack, ah, am, on, tick, stop, snz);
        #1;
        check_outputs();
    endtask

    task automatic idle_cycle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick1(input bit stop, input bit snz);
        tod = (tod + 1) % DAY_S;
        step(0, 0, 0, 0, 1, stop, snz);
    endtask

    task automatic jump(input int h, input int m, input int s);
        tod = h * 3600 + m * 60 + s;
        idle_cycle();
    endtask

    task automatic set_alarm(input int h, input int m, input bit on);
        step(1, h, m, on, 0, 0, 0);
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int r;
        int amin;
        rst = 1'b1;
        ack_flag = 0; i_hours = 0; i_minutes = 0; on_off_alarm = 0;
        sec_tick = 0; stop_button = 0; snooze_button = 0;
        cur_hours = 0; cur_minutes = 0; cur_seconds = 0;
        model_reset();
        #12;
        check_outputs();
        rst = 1'b0;

        // Stored alarm after reset is 00:00 disabled: midnight must not fire
        jump(23, 59, 59);
        tick1(0, 0);
        check("no_fire_after_reset", 32'(ringing), 32'd0);

        // 07:30 alarm fires once, times out after RING_SEC ticks
        set_alarm(7, 30, 1);
        jump(7, 29, 59);
        tick1(0, 0);
        check("ring_0730", 32'(ringing), 32'd1);
        for (int i = 0; i < RING_SEC + 3; i++) tick1(0, 0);
        check("timeout", 32'(ringing), 32'd0);

        // Stop, then 07:30:01 must not retrigger
        jump(7, 29, 59);
        tick1(0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        tick1(0, 0);
        check("no_fire_0730_01", 32'(ringing), 32'd0);

        // Snooze across midnight: 23:58 + 5 = 00:03
        set_alarm(23, 58, 1);
        jump(23, 57, 59);
        tick1(0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("snooze_1", 32'(snooze_cnt), 32'd1);
        jump(0, 2, 59);
        tick1(0, 0);
        check("wrap_ring_0003", 32'(ringing), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);

        // Snooze MAX_SNOOZE times, then one more acts as stop
        set_alarm(6, 0, 1);
        jump(5, 59, 59);
        tick1(0, 0);
        for (int k = 1; k <= MAX_SNOOZE; k++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            jump(6, 5 * k - 1, 59);
            tick1(0, 0);
        end
        check("ring_after_3", 32'(snooze_cnt), 32'(MAX_SNOOZE));
        step(0, 0, 0, 0, 0, 0, 1);
        check("fourth_snooze_idle", 32'(ringing) + 32'(snoozing) + 32'(snooze_cnt), 32'd0);

        // Stop and snooze together count as stop
        jump(5, 59, 59);
        tick1(0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        check("stop_snooze", 32'(snoozing), 32'd0);

        // Disable during SNOOZE: target match must not ring
        jump(5, 59, 59);
        tick1(0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        set_alarm(6, 0, 0);
        check("ack_off_idle", 32'(snoozing), 32'd0);
        jump(6, 4, 59);
        tick1(0, 0);
        check("no_ring_disabled", 32'(ringing), 32'd0);

        // Reset mid-ringing
        set_alarm(12, 0, 1);
        jump(11, 59, 59);
        tick1(0, 0);
        do_reset();
        jump(11, 59, 59);
        tick1(0, 0);
        check("alarm_cleared", 32'(ringing), 32'd0);

        // Randomized stimulus
        for (int c = 0; c < 6000; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                amin = (tod / 60 + int'($urandom_range(0, 2))) % DAY_M;
                set_alarm(amin / 60, amin % 60, $urandom_range(0, 9) != 0);
            end else if (r < 4) begin
                amin = m_snz ? m_tgt : m_al;
                tod  = (amin * 60 - int'($urandom_range(1, 4)) + DAY_S) % DAY_S;
                idle_cycle();
            end else if (r < 70) begin
                tick1($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0);
            end else begin
                step(0, 0, 0, 0, 0, $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
